// File: rtl/div_clk_checker_pkg.sv
// Shared definitions for the divided-clock checker slice.
//   state_t      : checker FSM states (idle / measuring)
//   DEF_*        : default parameter values used by the checker
package div_clk_checker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,   // waiting for an arming rise
    ST_MEAS = 1'b1    // measuring rise-to-rise periods
  } state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/div_clk_checker_rise_detect.sv
// rise_detect: one-cycle rising-edge pulse for a signal already synchronous
// to i_clk (no synchronizer stages).
//   i_clk  in  system clock
//   i_rst  in  asynchronous active-high reset (clears the history register)
//   i_d    in  sampled signal
//   o_rise out high for the cycle where i_d is 1 and was 0 the cycle before
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic d_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) d_q <= 1'b0;
    else       d_q <= i_d;
  end

  assign o_rise = i_d & ~d_q;

endmodule

// File: rtl/div_clk_checker.sv
// div_clk_checker: measures period and high time of a divided clock sampled
// in the i_clk domain, declares lock after LOCK_CNT consecutive good periods
// and raises a sticky error on a bad period or a lost clock.
//   i_clk    in   system clock, i_div is synchronous to it
//   i_rst    in   asynchronous active-high reset
//   i_div    in   divided clock under test
//   o_period out  last measured period (rise to rise), i_clk cycles
//   o_high   out  high cycles within that period
//   o_valid  out  one-cycle strobe when o_period/o_high update
//   o_locked out  LOCK_CNT consecutive periods matched N / EXP_HIGH
//   o_err    out  sticky mismatch/timeout flag, cleared only by reset
module div_clk_checker
  import div_clk_checker_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int EXP_HIGH = N / 2,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = 4 * N,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
  localparam logic [CNT_W-1:0] HIGH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_C = MW'(LOCK_CNT);

  logic rise;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [MW-1:0]    match, match_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             valid_nxt, locked_nxt, err_nxt;
  logic             good;

  rise_detect u_rise (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_div),
    .o_rise (rise)
  );

  // Counter values at the rise cover the whole previous period, since the
  // rise cycle of that period was loaded as count 1.
  assign good = (cnt == N_C) && (hcnt == HIGH_C);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == '1) ? cnt : cnt + ONE_C;
    hcnt_nxt   = (i_div && hcnt != '1) ? hcnt + ONE_C : hcnt;
    match_nxt  = match;
    period_nxt = o_period;
    high_nxt   = o_high;
    valid_nxt  = 1'b0;
    locked_nxt = o_locked;
    err_nxt    = o_err;

    if (rise) begin
      cnt_nxt  = ONE_C;
      hcnt_nxt = ONE_C;
    end

    unique case (state)
      ST_IDLE: begin
        if (rise) state_nxt = ST_MEAS;
      end
      ST_MEAS: begin
        // A rise coinciding with the timeout count is still a measurement.
        if (rise) begin
          period_nxt = cnt;
          high_nxt   = hcnt;
          valid_nxt  = 1'b1;
          if (good) begin
            match_nxt = (match == LOCK_C) ? match : match + 1'b1;
            if (match_nxt == LOCK_C) locked_nxt = 1'b1;
          end else begin
            match_nxt  = '0;
            locked_nxt = 1'b0;
            err_nxt    = 1'b1;
          end
        end else if (cnt >= TO_C) begin
          match_nxt  = '0;
          locked_nxt = 1'b0;
          err_nxt    = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      match    <= '0;
      o_period <= '0;
      o_high   <= '0;
      o_valid  <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hcnt     <= hcnt_nxt;
      match    <= match_nxt;
      o_period <= period_nxt;
      o_high   <= high_nxt;
      o_valid  <= valid_nxt;
      o_locked <= locked_nxt;
      o_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// Bench for div_clk_checker: drives i_div as a sequence of (high, low)
// periods and predicts outputs from an event-level model of periods, lock
// streak and timeouts.
module tb_div_clk_checker;

  localparam int N        = 8;
  localparam int EXP_HIGH = 4;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 32;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             div = 1'b0;
  logic [CNT_W-1:0] o_period, o_high;
  logic             o_valid, o_locked, o_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: knows the stimulus periods, not the RTL counters.
  bit m_armed;
  int prev_h, prev_l;
  int streak;
  bit m_err;
  int m_per, m_hi;

  div_clk_checker #(
    .N(N), .EXP_HIGH(EXP_HIGH), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_div    (div),
    .o_period (o_period),
    .o_high   (o_high),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_err    (o_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0;
    streak  = 0;
    m_err   = 1'b0;
    m_per   = 0;
    m_hi    = 0;
  endtask

  task automatic check_all(input string tag, input bit exp_valid);
    chk({tag, ".valid"},  o_valid,  exp_valid);
    chk({tag, ".locked"}, o_locked, (streak == LOCK_CNT));
    chk({tag, ".err"},    o_err,    m_err);
    chk({tag, ".period"}, o_period, m_per);
    chk({tag, ".high"},   o_high,   m_hi);
  endtask

  // One divided-clock period of h high then l low cycles; max_steps < h+l
  // cuts it short (used to reset mid-period).
  task automatic drive_period(input string tag, input int h, input int l, input int max_steps);
    int  per;
    bit  good, v;
    for (int i = 0; i < h + l && i < max_steps; i++) begin
      div = (i < h);
      @(posedge clk);
      #1;
      v = 1'b0;
      if (i == 0) begin
        if (m_armed) begin
          per   = prev_h + prev_l;
          good  = (per == N) && (prev_h == EXP_HIGH);
          m_per = per;
          m_hi  = prev_h;
          v     = 1'b1;
          if (good) streak = (streak < LOCK_CNT) ? streak + 1 : streak;
          else begin
            streak = 0;
            m_err  = 1'b1;
          end
        end else begin
          m_armed = 1'b1;
        end
        prev_h = h;
        prev_l = l;
      end
      // Lost clock: TIMEOUT cycles elapsed since the rise with no new rise.
      if (m_armed && i == TIMEOUT) begin
        m_armed = 1'b0;
        streak  = 0;
        m_err   = 1'b1;
      end
      check_all(tag, v);
    end
  endtask

  initial begin
    int r, h, l;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean 4/4 clock: arm, measure, lock after the fifth rise
    repeat (8) drive_period("clean", 4, 4, 1000);

    // Clock lost (held low) while locked
    drive_period("lost_low", 4, 40, 1000);
    repeat (6) drive_period("relock1", 4, 4, 1000);

    // One short period, then recovery
    drive_period("short", 3, 3, 1000);
    repeat (6) drive_period("relock2", 4, 4, 1000);

    // Duty error
    drive_period("duty", 5, 3, 1000);
    repeat (6) drive_period("relock3", 4, 4, 1000);

    // Stuck high
    drive_period("stuck_hi", 40, 1, 1000);
    repeat (6) drive_period("relock4", 4, 4, 1000);

    // Timeout boundary: 32-cycle period measures, 33 times out
    drive_period("edge32", 16, 16, 1000);
    drive_period("edge32b", 4, 4, 1000);
    drive_period("edge33", 16, 17, 1000);
    repeat (3) drive_period("edge_rec", 4, 4, 1000);

    // Randomized mix of good, bad and near-timeout periods
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        h = 4; l = 4;
      end else if (r < 9) begin
        h = $urandom_range(1, 10);
        l = $urandom_range(1, 10);
      end else begin
        h = $urandom_range(1, 20);
        l = $urandom_range(31, 34) - h;
      end
      drive_period("random", h, l, 1000);
    end

    // Asynchronous reset mid-high-phase while locked
    repeat (6) drive_period("prelock", 4, 4, 1000);
    drive_period("prereset", 4, 4, 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst", 1'b0);
    div = 1'b0;
    @(posedge clk);
    #1;
    check_all("in_rst", 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("post_rst", 1'b0);
    repeat (7) drive_period("after_rst", 4, 4, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
